// File: rtl/change_event_detector_pkg.sv
// Shared types for the change event detector: buffer states, source codes and
// the event payload carried from the debounce front end to the output slot.
package change_event_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT  = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [1:0] SRC_A = 2'b01;
    localparam logic [1:0] SRC_B = 2'b10;

    typedef struct packed {
        logic [1:0] src;
        logic       a;
        logic       b;
    } event_t;

    // Merge a newer change into a waiting event: sources accumulate, levels follow the newest.
    function automatic event_t coalesce(input event_t older, input event_t newer);
        event_t merged;
        merged.src = older.src | newer.src;
        merged.a   = newer.a;
        merged.b   = newer.b;
        return merged;
    endfunction

endpackage

// File: rtl/change_event_detector_debounce.sv
// One input channel: two-flop synchronizer, glitch-rejecting run counter and
// the committed (stable) level, with a single-cycle commit pulse on each change.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_stable,
    output logic o_commit
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_commit;

    assign w_differ = (r_sync2 != r_stable);
    // The commit fires on the sample that completes the run, so the new level is
    // visible in the same edge that loads it into the event buffer.
    assign w_commit = w_differ && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_level;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_cnt    <= '0;
                r_stable <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_commit = w_commit;

endmodule

// File: rtl/change_event_detector.sv
// Debounced change events for inputs a and b, delivered through a two-slot
// valid/ready buffer with an accepted-event counter and sticky overflow flag.
module change_event_detector
    import change_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_src,
    output logic             evt_a,
    output logic             evt_b,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    output state_t           o_dbg_state
);

    // Handshake: an event transfers on any edge where evt_valid and evt_ready are
    // both high; until then the payload holds and evt_valid stays asserted.

    logic       w_stable_a;
    logic       w_stable_b;
    logic       w_commit_a;
    logic       w_commit_b;
    logic       w_commit;
    logic       w_accept;
    event_t     w_new;

    state_t           r_state;
    event_t           r_out;
    event_t           r_queue;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .rst      (rst),
        .i_level  (a_in),
        .o_stable (w_stable_a),
        .o_commit (w_commit_a)
    );

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .rst      (rst),
        .i_level  (b_in),
        .o_stable (w_stable_b),
        .o_commit (w_commit_b)
    );

    // A committing input flips its level this edge, so the post-update level is stable ^ commit.
    always_comb begin
        w_new     = '0;
        w_new.src = (w_commit_a ? SRC_A : 2'b00) | (w_commit_b ? SRC_B : 2'b00);
        w_new.a   = w_stable_a ^ w_commit_a;
        w_new.b   = w_stable_b ^ w_commit_b;
    end

    assign w_commit = w_commit_a | w_commit_b;
    assign w_accept = (r_state != IDLE) && evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_out      <= '0;
            r_queue    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_commit) begin
                        r_out   <= w_new;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (w_accept) begin
                        if (w_commit) begin
                            r_out <= w_new;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_commit) begin
                        r_queue <= w_new;
                        r_state <= FULL;
                    end
                end
                FULL: begin
                    if (w_accept) begin
                        r_out <= r_queue;
                        if (w_commit) begin
                            r_queue <= w_new;
                        end else begin
                            r_state <= OUT;
                        end
                    end else if (w_commit) begin
                        r_queue    <= coalesce(r_queue, w_new);
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid   = (r_state != IDLE);
    assign evt_src     = r_out.src;
    assign evt_a       = r_out.a;
    assign evt_b       = r_out.b;
    assign evt_count   = r_count;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: doc/change_event_detector.md
# change_event_detector

Front-end stage that produces the "a or b changed" events consumed by the always-block demonstration logic. It synchronizes two asynchronous level inputs, debounces each one, and turns every committed level change into a buffered event. Each event is delivered over a valid/ready handshake, with an accepted-event counter and a sticky overflow flag.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples required before a new level commits (≥1)
- CNT_W, 8, width of the accepted-event counter
- clk  in  1  single clock; all state is updated on its rising edge
- rst  in  1  asynchronous, active-high reset
- a_in  in  1  asynchronous level input a
- b_in  in  1  asynchronous level input b
- evt_valid  out  1  event available at the output
- evt_ready  in  1  downstream accepts the event
- evt_src  out  2  bit0 = a changed, bit1 = b changed; never 2'b00 while evt_valid
- evt_a  out  1  committed level of a carried by the event
- evt_b  out  1  committed level of b carried by the event
- evt_count  out  CNT_W  number of accepted events, modulo 2^CNT_W
- overflow  out  1  sticky: a change was coalesced because the buffer was full

## Operation
- Synchronizer: two flops per input, sync1 then sync2.
- Debounce, per input:
  - Counter runs while sync2 ≠ stable; it clears when sync2 = stable, so glitches are rejected.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, stable ← sync2 and a commit pulse fires for that input.
- Commit: if a and b both commit in the same cycle, they form one event with src=2'b11. Payload is {src, stable_a, stable_b} after the update.
- Buffer FSM: IDLE, OUT (output slot full), FULL (output slot plus one queued slot).
  - IDLE + commit → OUT, payload written to the output slot.
  - OUT + accept, no commit → IDLE.
  - OUT + accept + commit → OUT, new payload written to the output slot.
  - OUT + commit, no accept → FULL, payload written to the queue.
  - FULL + accept, no commit → OUT, queue moves to the output slot.
  - FULL + accept + commit → FULL, queue moves to the output slot and the new payload enters the queue.
  - FULL + commit, no accept → stays FULL. Queue is coalesced: src ORed, levels replaced by the latest. overflow ← 1.
- Accept = evt_valid & evt_ready.
  - The output payload is stable while evt_valid is high and not accepted.
  - evt_valid never drops without an accept.
- evt_count increments by 1 on each accept and wraps from 2^CNT_W−1 to 0.
- overflow clears only on reset.

## Timing
- Reset values:
  - evt_valid=0, evt_src=0, evt_a=0, evt_b=0, evt_count=0, overflow=0.
  - Sync flops, stable levels and debounce counters reset to 0. FSM state is IDLE.
- Reset asserted mid-operation clears all state immediately, including pending and queued events.
- An input that is high when reset releases produces an event after the normal latency.
- Latency: input new level first sampled at edge 0 and held → stable updates and evt_valid goes high at edge DEBOUNCE_CYCLES+1. With the default of 4, that is edge 5.
- A pulse lasting fewer than DEBOUNCE_CYCLES synchronized samples produces no event.
- Evt_ready is combinationally unused for evt_valid: no combinational path from evt_ready to any output.
- Throughput: one accept per cycle. An output freed by an accept refills in the same edge from the queue or from a new commit.

## Structure
- Package change_event_pkg holds:
  - state enum {IDLE, OUT, FULL};
  - localparams SRC_A=2'b01, SRC_B=2'b10;
  - packed event struct {src[1:0], a, b}.
- Sub-module debounce_cell (parameter DEBOUNCE_CYCLES) contains the synchronizer, counter and stable register for one input. It outputs the stable level and a one-cycle commit pulse. It is instantiated twice.
- Top level contains the commit merge, the 2-slot buffer FSM, evt_count and overflow.

## Test plan
- Reset, then raise a_in at edge 0 with evt_ready=1 → evt_valid at edge 5 with src=01, a=1, b=0; accepted; evt_count=1.
- 3-cycle glitch on b_in (DEBOUNCE_CYCLES=4) → no event, evt_count stays 0.
- a_in and b_in toggled on the same edge → a single event with src=11 and evt_count +1.
- evt_ready=0; toggle a, then b, then a again, each spaced 10 cycles:
  - output holds the first event unchanged;
  - queue holds src=11 with the latest levels;
  - overflow=1.
  - Then evt_ready=1 → 2 accepts; evt_count +2.
- CNT_W=2: 5 accepted events → evt_count reads 1 after wrapping.
- Assert rst while in FULL → all outputs return to reset values next edge; no stale event after release.
